tohost_monitor: RTL
===================

TOHOST_MONITOR -- requirements
Module: tohost_monitor

Interface
REQ-001 SHALL have parameter TOHOST_ADDR, default 32'h8000_1000, the byte address of the tohost mailbox.
REQ-002 SHALL have parameter WDOG_CYCLES, default 1000000, the watchdog limit in clock cycles (used only with REQ-030).
REQ-003 clock  input  1  the sole clock; all state is updated on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  write request valid.
REQ-006 req_ready  output  1  write request accepted when req_valid && req_ready.
REQ-007 req_addr  input  32  write byte address.
REQ-008 req_data  input  64  write data.
REQ-009 char_valid  output  1  console character available.
REQ-010 char_ready  input  1  console sink accepts the character.
REQ-011 char_data  output  8  console character.
REQ-012 io_success  output  1  test passed; sticky.
REQ-013 io_failure  output  1  test failed; sticky.
REQ-014 exit_code  output  32  decoded exit code; valid while io_success or io_failure is high.

Function
REQ-015 SHALL implement the states RUN, CHAR, PASS and FAIL.
REQ-016 A write SHALL be accepted only on a cycle where req_valid && req_ready.
REQ-017 req_ready SHALL be 1 in RUN, PASS and FAIL, and 0 in CHAR.
REQ-018 An accepted write with req_addr != TOHOST_ADDR SHALL be ignored and leave the state unchanged.
REQ-019 Exit command: an accepted tohost write with data[63:48]==0 and data[0]==1 SHALL load exit_code=data[32:1] and go to PASS if the code is 0, otherwise to FAIL.
REQ-020 Console command: an accepted tohost write with data[63:48]==16'h0101 SHALL load char_data=data[7:0] and go to CHAR.
REQ-021 Any other tohost write, including data==0, SHALL be ignored.
REQ-022 Latency: a command accepted in cycle N SHALL make io_success, io_failure or char_valid visible in cycle N+1.
REQ-023 char_valid SHALL be 1 only in CHAR; char_data SHALL stay stable while char_valid is high.
REQ-024 CHAR SHALL return to RUN on the cycle char_valid && char_ready.
REQ-025 No new request SHALL be accepted in the cycle CHAR exits.
REQ-026 PASS and FAIL SHALL be terminal until reset.
REQ-027 In PASS and FAIL, writes SHALL be accepted and discarded, and exit_code SHALL be frozen.
REQ-028 io_success SHALL equal (state==PASS) and io_failure SHALL equal (state==FAIL), both registered.

Reset
REQ-029 While reset==0 at a rising edge: state=RUN, char_valid=0, char_data=0, io_success=0, io_failure=0, exit_code=0, watchdog count=0; req_ready=1 out of reset. A reset asserted mid-CHAR SHALL drop the pending character.

Configuration
REQ-030 With TOHOST_MONITOR_WATCHDOG_EN defined:
- a 32-bit counter SHALL increment each cycle in RUN or CHAR.
- On reaching WDOG_CYCLES the block SHALL go to FAIL with exit_code=32'hFFFF_FFFF.
- If an exit command is accepted in the same cycle the count reaches WDOG_CYCLES, the exit command SHALL win.
- The counter SHALL saturate and hold in PASS and FAIL.
REQ-031 Without TOHOST_MONITOR_WATCHDOG_EN, no counter SHALL be instantiated and FAIL SHALL be reachable only by an exit command.

Structure
REQ-032 Package tohost_monitor_pkg SHALL hold:
- the state enum;
- constants HTIF_DEV_CONSOLE=8'h01, HTIF_CMD_PUTC=8'h01 and WDOG_EXIT_CODE=32'hFFFF_FFFF.
REQ-033 The watchdog SHALL be a sub-module, tohost_watchdog (inputs enable and clear, output expired), instantiated only under TOHOST_MONITOR_WATCHDOG_EN.

Verification
REQ-034 Pass case: write TOHOST_ADDR, data 64'h1 -> io_success=1 one cycle later, exit_code=0, io_failure=0, held for 100 cycles.
REQ-035 Fail case: write TOHOST_ADDR, data 64'h7 -> io_failure=1, exit_code=3; a later write of 64'h1 leaves both outputs unchanged.
REQ-036 Console case: write data 64'h0101_0000_0000_0041 with char_ready=0 for 5 cycles:
- char_valid=1 and char_data=8'h41 held stable;
- req_ready=0 throughout the stall;
- RUN is re-entered after the char_ready handshake.
REQ-037 Ignore case: writes to TOHOST_ADDR+8 with data 64'h1, and a tohost write with data 0 -> no state change and no outputs asserted.
REQ-038 Watchdog case: with the macro defined and WDOG_CYCLES=50, send no writes -> io_failure=1 and exit_code=32'hFFFF_FFFF at cycle 51.
- Same setup with a 64'h1 write in cycle 50 -> io_success=1 instead.
REQ-039 Reset case: pull reset low while in CHAR -> char_valid=0 and the state returns to RUN on the next edge.

Source files
------------

// File: rtl/tohost_monitor_pkg.sv
// Shared types and constants for the tohost mailbox monitor.
package tohost_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_CHAR,
        ST_PASS,
        ST_FAIL
    } mon_state_e;

    localparam logic [7:0]  HTIF_DEV_CONSOLE = 8'h01;
    localparam logic [7:0]  HTIF_CMD_PUTC    = 8'h01;
    localparam logic [31:0] WDOG_EXIT_CODE   = 32'hFFFF_FFFF;

endpackage

// File: rtl/tohost_watchdog.sv
// Free-running cycle watchdog; expired pulses in the cycle the count reaches WDOG_CYCLES.
module tohost_watchdog #(
    parameter int unsigned WDOG_CYCLES = 1000000
) (
    input  logic clock,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [31:0] LIMIT = 32'(WDOG_CYCLES);

    logic [31:0] count_q;
    logic [31:0] count_inc;

    assign count_inc = count_q + 32'd1;
    assign expired   = enable && (count_inc == LIMIT);

    // Holds whenever disabled and never wraps past all-ones.
    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= '0;
        end else if (enable && (count_q != '1)) begin
            count_q <= count_inc;
        end
    end

endmodule

// File: rtl/tohost_monitor.sv
// Decodes HTIF-style tohost writes into console characters and a pass/fail verdict.
// Optional watchdog enabled by defining TOHOST_MONITOR_WATCHDOG_EN.
module tohost_monitor
    import tohost_monitor_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR = 32'h8000_1000,
    parameter int unsigned WDOG_CYCLES = 1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_data,
    output logic        char_valid,
    input  logic        char_ready,
    output logic [7:0]  char_data,
    output logic        io_success,
    output logic        io_failure,
    output logic [31:0] exit_code
);

    mon_state_e  state_q, state_d;
    logic [31:0] exit_code_q, exit_code_d;
    logic [7:0]  char_data_q, char_data_d;

    logic accept;
    logic is_tohost;
    logic is_exit;
    logic is_putc;
    logic wdog_expired;
    logic unused_data_bits;

    assign accept    = req_valid && req_ready;
    assign is_tohost = accept && (req_addr == TOHOST_ADDR);
    assign is_exit   = is_tohost && (req_data[63:48] == '0) && req_data[0];
    assign is_putc   = is_tohost && (req_data[63:48] == {HTIF_DEV_CONSOLE, HTIF_CMD_PUTC});
    assign unused_data_bits = ^req_data[47:33];

`ifdef TOHOST_MONITOR_WATCHDOG_EN
    tohost_watchdog #(
        .WDOG_CYCLES(WDOG_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .clear  (!reset),
        .enable ((state_q == ST_RUN) || (state_q == ST_CHAR)),
        .expired(wdog_expired)
    );
`else
    localparam int unsigned unused_wdog_cycles = WDOG_CYCLES;
    assign wdog_expired = 1'b0;
`endif

    assign req_ready  = (state_q != ST_CHAR);
    assign char_valid = (state_q == ST_CHAR);
    assign char_data  = char_data_q;
    assign io_success = (state_q == ST_PASS);
    assign io_failure = (state_q == ST_FAIL);
    assign exit_code  = exit_code_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            exit_code_q <= '0;
            char_data_q <= '0;
        end else begin
            state_q     <= state_d;
            exit_code_q <= exit_code_d;
            char_data_q <= char_data_d;
        end
    end

    // An exit command beats a same-cycle watchdog expiry; expiry beats a console write.
    always_comb begin
        state_d     = state_q;
        exit_code_d = exit_code_q;
        char_data_d = char_data_q;
        case (state_q)
            ST_RUN: begin
                if (is_exit) begin
                    exit_code_d = req_data[32:1];
                    state_d     = (req_data[32:1] == '0) ? ST_PASS : ST_FAIL;
                end else if (wdog_expired) begin
                    exit_code_d = WDOG_EXIT_CODE;
                    state_d     = ST_FAIL;
                end else if (is_putc) begin
                    char_data_d = req_data[7:0];
                    state_d     = ST_CHAR;
                end
            end
            ST_CHAR: begin
                if (wdog_expired) begin
                    exit_code_d = WDOG_EXIT_CODE;
                    state_d     = ST_FAIL;
                end else if (char_ready) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

endmodule
